// File: rtl/waveform_meter_pkg.sv
// Shared definitions for the waveform period meter: FSM encoding and
// Schmitt threshold helpers around the 8-bit unsigned midpoint.
package waveform_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    localparam int MIDPOINT = 128;

    // Rising threshold: LOW->HIGH when sample >= MIDPOINT+hyst.
    function automatic logic [7:0] upper_thr(input int hyst);
        return 8'(MIDPOINT + hyst);
    endfunction

    // Falling threshold: HIGH->LOW when sample <= MIDPOINT-1-hyst.
    function automatic logic [7:0] lower_thr(input int hyst);
        return 8'(MIDPOINT - 1 - hyst);
    endfunction

endpackage

// File: rtl/schmitt_edge_detector.sv
// Hysteretic midpoint comparator; edge_hit flags the enabled sample that
// takes the registered level from LOW to HIGH.
module schmitt_edge_detector
    import waveform_meter_pkg::*;
#(
    parameter int HYST = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] sample_in,
    output logic       level,
    output logic       edge_hit
);

    localparam logic [7:0] THR_HI = upper_thr(HYST);
    localparam logic [7:0] THR_LO = lower_thr(HYST);

    logic above_hi;
    logic below_lo;

    assign above_hi = (sample_in >= THR_HI);
    assign below_lo = (sample_in <= THR_LO);

    // Combinational on the current sample so the crossing sample is the event.
    assign edge_hit = enable && !level && above_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
        end else if (enable) begin
            if (!level && above_hi)
                level <= 1'b1;
            else if (level && below_lo)
                level <= 1'b0;
        end
    end

endmodule

// File: rtl/waveform_period_meter.sv
// Measures the period (in enabled samples) of an 8-bit waveform between
// rising Schmitt crossings, averaged over 2^AVG_LOG2 cycles, plus peak/trough.
module waveform_period_meter
    import waveform_meter_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int HYST     = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [7:0]          sample_in,
    output logic [PERIOD_W-1:0] period_out,
    output logic [7:0]          peak_out,
    output logic [7:0]          trough_out,
    output logic                period_valid,
    output logic                locked,
    output logic                timeout
);

    localparam int SUM_W = PERIOD_W + AVG_LOG2;
    localparam logic [PERIOD_W-1:0] CNT_SAT  = {PERIOD_W{1'b1}};
    localparam logic [AVG_LOG2-1:0] WIN_LAST = {AVG_LOG2{1'b1}};

    meter_state_t        state;
    logic [PERIOD_W-1:0] cnt;
    logic [SUM_W-1:0]    sum;
    logic [AVG_LOG2-1:0] win;
    logic [7:0]          run_max;
    logic [7:0]          run_min;

    logic                level_unused;
    logic                edge_hit;
    logic [PERIOD_W-1:0] cnt_inc;
    logic                cnt_sat;
    logic [SUM_W-1:0]    total;
    logic [SUM_W-1:0]    avg;
    logic [7:0]          nxt_max;
    logic [7:0]          nxt_min;

    schmitt_edge_detector #(
        .HYST(HYST)
    ) u_schmitt (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sample_in(sample_in),
        .level    (level_unused),
        .edge_hit (edge_hit)
    );

    assign cnt_inc = cnt + 1'b1;
    assign cnt_sat = (cnt_inc == CNT_SAT);
    // The edge sample closes the period, hence the +1.
    assign total   = sum + {{AVG_LOG2{1'b0}}, cnt} + SUM_W'(1);
    assign avg     = total >> AVG_LOG2;
    assign nxt_max = (sample_in > run_max) ? sample_in : run_max;
    assign nxt_min = (sample_in < run_min) ? sample_in : run_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sum          <= '0;
            win          <= '0;
            run_max      <= '0;
            run_min      <= '0;
            period_out   <= '0;
            peak_out     <= '0;
            trough_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        sum <= '0;
                        win <= '0;
                        if (edge_hit) begin
                            state   <= MEASURE;
                            run_max <= sample_in;
                            run_min <= sample_in;
                        end
                    end
                    MEASURE: begin
                        if (edge_hit) begin
                            cnt <= '0;
                            if (win == WIN_LAST) begin
                                period_out   <= avg[PERIOD_W-1:0];
                                peak_out     <= nxt_max;
                                trough_out   <= nxt_min;
                                period_valid <= 1'b1;
                                locked       <= 1'b1;
                                sum          <= '0;
                                win          <= '0;
                                run_max      <= sample_in;
                                run_min      <= sample_in;
                            end else begin
                                sum     <= total;
                                win     <= win + 1'b1;
                                run_max <= nxt_max;
                                run_min <= nxt_min;
                            end
                        end else if (cnt_sat) begin
                            // No crossing within range: drop back and re-arm.
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                            state   <= IDLE;
                            cnt     <= '0;
                            sum     <= '0;
                            win     <= '0;
                        end else begin
                            cnt     <= cnt_inc;
                            run_max <= nxt_max;
                            run_min <= nxt_min;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
